// File: rtl/hrange_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hrange_gen : streams base, base+step, ... to a bound over ready/valid        |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module hrange_gen #(
  parameter int WIDTH     = 32,
  parameter bit INCLUSIVE = 1'b0,
  parameter int MAX_COUNT = 0
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  input  logic             _start,
  input  logic             _ready,
  output logic             _valid,
  output logic             _done,
  output logic             _err,
  output logic [WIDTH-1:0] _count,
  output logic [WIDTH-1:0] _0
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   next_sum;
  logic [WIDTH-1:0] next_val;
  logic             next_ovf;
  logic             xfer;
  logic             cap_hit;

  // Direction comes from the sign of the captured step.
  function automatic logic in_bound(input logic [WIDTH-1:0] v,
                                    input logic [WIDTH-1:0] lim,
                                    input logic             desc);
    logic r;
    if (desc) begin
      r = INCLUSIVE ? ($signed(v) >= $signed(lim)) : ($signed(v) > $signed(lim));
    end else begin
      r = INCLUSIVE ? ($signed(v) <= $signed(lim)) : ($signed(v) < $signed(lim));
    end
    return r;
  endfunction

  assign next_sum = {val_q[WIDTH-1], val_q} + {step_q[WIDTH-1], step_q};
  assign next_val = next_sum[WIDTH-1:0];
  assign next_ovf = next_sum[WIDTH] ^ next_sum[WIDTH-1];
  assign xfer     = valid_q & _ready;

  generate
    if (MAX_COUNT > 0) begin : g_cap
      localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_COUNT);
      assign cap_hit = xfer && ((count_q + WIDTH'(1)) == C_MAX);
    end else begin : g_nocap
      assign cap_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    step_d  = step_q;
    val_d   = val_q;
    count_d = count_q;
    valid_d = _ready ? 1'b0 : valid_q;
    done_d  = 1'b0;
    err_d   = err_q;

    if (_start) begin
      lim_d   = limit;
      step_d  = step;
      count_d = '0;
      err_d   = 1'b0;
      valid_d = 1'b0;
      if (step == '0) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else if (in_bound(base, limit, step[WIDTH-1])) begin
        val_d   = base;
        valid_d = 1'b1;
        state_d = S_RUN;
      end else begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end else if (state_q == S_RUN && (_ready || !valid_q)) begin
      if (xfer) begin
        count_d = count_q + WIDTH'(1);
      end
      if (cap_hit) begin
        done_d  = 1'b1;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end else if (next_ovf) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end else if (!in_bound(next_val, lim_q, step_q[WIDTH-1])) begin
        done_d  = 1'b1;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end else begin
        val_d   = next_val;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q <= S_IDLE;
      lim_q   <= '0;
      step_q  <= '0;
      val_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      step_q  <= step_d;
      val_q   <= val_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign _valid = valid_q;
  assign _done  = done_q;
  assign _err   = err_q;
  assign _count = count_q;
  assign _0     = val_q;

endmodule
`default_nettype wire

// File: tb/tb_hrange_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hrange_gen : scoreboard bench over four parameterisations of hrange_gen   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_hrange_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, ready;
  logic [31:0] base, limit, step;

  always #5 clk = ~clk;

  // 0: exclusive W32, 1: inclusive W32, 2: exclusive W8, 3: cap=3 W32
  logic        v_e, d_e, r_e, v_i, d_i, r_i, v_w, d_w, r_w, v_c, d_c, r_c;
  logic [31:0] c_e, o_e, c_i, o_i, c_c, o_c;
  logic [7:0]  c_w, o_w;

  hrange_gen #(.WIDTH(32), .INCLUSIVE(1'b0), .MAX_COUNT(0)) u_exc (
    ._clock(clk), ._reset(rst), .base(base), .limit(limit), .step(step),
    ._start(start), ._ready(ready), ._valid(v_e), ._done(d_e), ._err(r_e),
    ._count(c_e), ._0(o_e));
  hrange_gen #(.WIDTH(32), .INCLUSIVE(1'b1), .MAX_COUNT(0)) u_inc (
    ._clock(clk), ._reset(rst), .base(base), .limit(limit), .step(step),
    ._start(start), ._ready(ready), ._valid(v_i), ._done(d_i), ._err(r_i),
    ._count(c_i), ._0(o_i));
  hrange_gen #(.WIDTH(8), .INCLUSIVE(1'b0), .MAX_COUNT(0)) u_w8 (
    ._clock(clk), ._reset(rst), .base(base[7:0]), .limit(limit[7:0]), .step(step[7:0]),
    ._start(start), ._ready(ready), ._valid(v_w), ._done(d_w), ._err(r_w),
    ._count(c_w), ._0(o_w));
  hrange_gen #(.WIDTH(32), .INCLUSIVE(1'b0), .MAX_COUNT(3)) u_cap (
    ._clock(clk), ._reset(rst), .base(base), .limit(limit), .step(step),
    ._start(start), ._ready(ready), ._valid(v_c), ._done(d_c), ._err(r_c),
    ._count(c_c), ._0(o_c));

  int          sel;
  logic        obs_valid, obs_done, obs_err;
  logic [31:0] obs_cnt, obs_val;

  always_comb begin
    obs_valid = v_e; obs_done = d_e; obs_err = r_e; obs_cnt = c_e; obs_val = o_e;
    case (sel)
      1: begin obs_valid = v_i; obs_done = d_i; obs_err = r_i; obs_cnt = c_i; obs_val = o_i; end
      2: begin
        obs_valid = v_w; obs_done = d_w; obs_err = r_w;
        obs_cnt = {24'd0, c_w}; obs_val = {{24{o_w[7]}}, o_w};
      end
      3: begin obs_valid = v_c; obs_done = d_c; obs_err = r_c; obs_cnt = c_c; obs_val = o_c; end
      default: ;
    endcase
  end

  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  logic [31:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [31:0] hold_v, hold_c;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Sampled mid-cycle: a valid&&ready seen here is transferred on the next edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && !start) begin
        check_eq("hold_valid", {31'd0, obs_valid}, 32'd1);
        check_eq("hold_value", obs_val, hold_v);
        check_eq("hold_count", obs_cnt, hold_c);
      end
      if (obs_valid && ready && !start) begin
        if (exp_q.size() == 0) check_eq("extra_value", {31'd0, obs_valid}, 32'd0);
        else                   check_eq("value", obs_val, exp_q.pop_front());
      end
      hold_pend = obs_valid && !ready && !start;
      hold_v    = obs_val;
      hold_c    = obs_cnt;
      if (obs_done) begin
        done_seen++;
        check_eq("done_after_last", exp_q.size(), 32'd0);
      end
    end
  end

  task automatic run_seq(input int s, input logic [31:0] b, input logic [31:0] l,
                         input logic [31:0] st, input logic [15:0] pat,
                         input logic [31:0] exp_cnt, input logic exp_err, input string tag);
    int  k;
    int  d0;
    logic nonempty;
    sel      = s;
    d0       = done_seen;
    nonempty = (exp_q.size() != 0);
    @(posedge clk); #1;
    base = b; limit = l; step = st; start = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; ready = pat[0];
    base = $urandom; limit = $urandom; step = $urandom;
    check_eq({tag, "_first_valid"}, {31'd0, obs_valid}, {31'd0, nonempty});
    if (!nonempty) check_eq({tag, "_empty_done"}, {31'd0, obs_done}, 32'd1);
    k = 0;
    while (done_seen == d0 && k < 200) begin
      @(posedge clk); #1;
      k++;
      ready = pat[k % 16];
    end
    check_eq({tag, "_finished"}, {31'd0, (k < 200)}, 32'd1);
    check_eq({tag, "_count"}, obs_cnt, exp_cnt);
    check_eq({tag, "_err"}, {31'd0, obs_err}, {31'd0, exp_err});
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_done_pulses"}, done_seen - d0, 32'd1);
    check_eq({tag, "_queue_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
    ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; ready = 1'b0; base = '0; limit = '0; step = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, obs_valid}, 32'd0);
    check_eq("rst_done",  {31'd0, obs_done},  32'd0);
    check_eq("rst_err",   {31'd0, obs_err},   32'd0);
    check_eq("rst_count", obs_cnt, 32'd0);
    check_eq("rst_value", obs_val, 32'd0);
    rst = 1'b0;

    exp_q = '{32'd0, 32'd2, 32'd4, 32'd6, 32'd8};
    run_seq(0, 32'd0, 32'd10, 32'd2, 16'hFFFF, 32'd5, 1'b0, "basic");

    exp_q = '{32'd5, 32'd2, -32'sd1};
    run_seq(1, 32'd5, -32'sd1, -32'sd3, 16'hFFFF, 32'd3, 1'b0, "desc_incl");

    exp_q = '{32'd0, 32'd1, 32'd2};
    run_seq(0, 32'd0, 32'd3, 32'd1, 16'b0110_1010_1011_1001, 32'd3, 1'b0, "backpressure");

    run_seq(0, 32'd10, 32'd0, 32'd1, 16'hFFFF, 32'd0, 1'b0, "empty");

    run_seq(0, 32'd4, 32'd9, 32'd0, 16'hFFFF, 32'd0, 1'b1, "step_zero");

    exp_q = '{32'd0, 32'd1, 32'd2};
    run_seq(3, 32'd0, 32'd100, 32'd1, 16'hFFFF, 32'd3, 1'b0, "cap");

    exp_q = '{32'd120, 32'd125};
    run_seq(2, 32'd120, 32'd127, 32'd5, 16'hFFFF, 32'd2, 1'b1, "overflow");

    exp_q = '{32'd3, 32'd2, 32'd1};
    run_seq(0, 32'd3, 32'd0, -32'sd1, 16'b1011_0111_0110_1101, 32'd3, 1'b0, "desc_excl");

    exp_q = '{32'd0, 32'd2, 32'd4};
    run_seq(1, 32'd0, 32'd4, 32'd2, 16'hFFFF, 32'd3, 1'b0, "asc_incl");

    // Asynchronous reset between edges mid-run
    sel = 0;
    exp_q = '{32'd0, 32'd1, 32'd2};
    @(posedge clk); #1;
    base = 32'd0; limit = 32'd100; step = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ready = 1'b0;
    check_eq("pre_rst_count", obs_cnt, 32'd3);
    check_eq("pre_rst_value", obs_val, 32'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", {31'd0, obs_valid}, 32'd0);
    check_eq("arst_done",  {31'd0, obs_done},  32'd0);
    check_eq("arst_count", obs_cnt, 32'd0);
    check_eq("arst_value", obs_val, 32'd0);
    check_eq("arst_queue", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Restart mid-run: pending value dropped, only the new run signals done
    d0 = done_seen;
    exp_q = '{32'd0, 32'd1, 32'd2};
    @(posedge clk); #1;
    base = 32'd0; limit = 32'd100; step = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(32'd50); exp_q.push_back(32'd51); exp_q.push_back(32'd52);
    base = 32'd50; limit = 32'd53; step = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("restart_first", obs_val, 32'd50);
    check_eq("restart_count0", obs_cnt, 32'd0);
    for (int k = 0; k < 50 && done_seen == d0; k++) @(posedge clk);
    #1;
    check_eq("restart_count", obs_cnt, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    check_eq("restart_done_pulses", done_seen - d0, 32'd1);
    check_eq("restart_queue", exp_q.size(), 32'd0);
    ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hrange_gen.md
Name: hrange_gen

Overview:
- Parametrised successor of the generator-style range block.
- Streams base, base+step, base+2*step, … until the range bound is reached.
- Extended over the previous generation with:
  - configurable width;
  - negative (descending) steps;
  - inclusive or exclusive bound;
  - an optional element cap;
  - arithmetic-overflow detection;
  - an emitted-count output and an error flag.
- Feeds downstream func_call consumers through the team's ready/valid handshake.

Parameters:
- WIDTH, 32, bit width of base/limit/step/_0 (signed two's complement).
- INCLUSIVE, 0, 0: bound test excludes limit (i<limit / i>limit); 1: includes limit (i<=limit / i>=limit).
- MAX_COUNT, 0, 0: unlimited; N>0: terminate after N values accepted by the consumer.

Ports:
- _clock  input  1  clock, rising edge.
- _reset  input  1  asynchronous, active-high reset; forces idle with _done low.
- base  input  WIDTH  first value, signed; sampled on _start.
- limit  input  WIDTH  bound, signed; sampled on _start.
- step  input  WIDTH  increment, signed, may be negative; sampled on _start.
- _start  input  1  capture inputs this cycle and begin generating.
- _ready  input  1  consumer ready for output.
- _valid  output  1  _0 holds a valid value.
- _done  output  1  one-cycle pulse: sequence finished.
- _err  output  1  level: last run ended on step==0 or overflow; cleared by _start.
- _count  output  WIDTH  values handed over so far in the current run, unsigned.
- _0  output  WIDTH  current value, signed.

Behaviour:
- Clock and reset: one clock (_clock); reset (_reset) is asynchronous and active-high.
- Reset (asynchronous, takes effect immediately, overrides _start):
  - state=IDLE;
  - _valid=0, _done=0, _err=0;
  - _count=0, _0=0;
  - captured registers cleared.
- States: IDLE, RUN.
- Bound test, with dir = sign of captured step:
  - step>0: continue while v<limit (v<=limit if INCLUSIVE);
  - step<0: continue while v>limit (v>=limit if INCLUSIVE).
- Default each cycle: _done<=0; if _ready, _valid<=0.
- On _start (any state, including mid-run; the old run is abandoned without a _done pulse):
  - capture base/limit/step; _count<=0, _err<=0.
  - If step==0: _err<=1, _done<=1, state<=IDLE.
  - Else if base passes the bound test: _0<=base, _valid<=1, state<=RUN.
  - Else: _done<=1, state<=IDLE.
  - First value is valid the edge after _start (latency 1).
- RUN, advancing only when _ready || !_valid (so an unaccepted value is never overwritten):
  - _count increments by 1 on every accepted transfer (_valid && _ready at the edge).
  - next = i + step, computed in WIDTH+1 bits.
  - Termination, in priority order:
    1. MAX_COUNT>0 and the accepted total reaches MAX_COUNT;
    2. next does not fit WIDTH signed (overflow) -> also _err<=1;
    3. next fails the bound test.
  - On termination: _done<=1, state<=IDLE.
  - Otherwise: _0<=next, _valid<=1, i<=next.
- Throughput: one value per cycle while _ready is held high.
- _done pulses on the cycle after the last value is accepted.
- Holding behaviour: while _valid && !_ready, _0, _valid and _count are stable.
- In IDLE, _ready has no effect; _0 retains its last value.
- _start and _ready together: _start wins; a pending value is dropped and is not counted.
- Inputs are ignored except in the _start cycle.

Test Plan:
- Basic exclusive range: INCLUSIVE=0, base=0, limit=10, step=2, _ready=1 -> _0 = 0,2,4,6,8 on consecutive cycles, _done pulses the next cycle, _count=5, _err=0.
- Descending inclusive range: INCLUSIVE=1, base=5, limit=-1, step=-3 -> 5, 2, -1, then _done; _count=3.
- Backpressure: base=0, limit=3, step=1, _ready toggled 1,0,0,1,1,… -> each value held stable while _ready=0; no value lost or duplicated; output 0,1,2.
- Empty range and step==0:
  - base=10, limit=0, step=1 -> no _valid; _done pulses 1 cycle after _start.
  - step=0 -> _done and _err=1.
- Overflow and cap:
  - WIDTH=8, base=120, limit=127, step=5 -> 120, 125, then _done with _err=1.
  - MAX_COUNT=3, base=0, limit=100, step=1 -> 0,1,2, then _done.
- Asynchronous reset and restart:
  - Assert _reset mid-run between clock edges -> _valid and _done drop immediately, _count=0.
  - _start during a run -> new sequence begins, no _done pulse for the old run.
